// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, types and the write-hit helper for the
// multi-port register file.
//   REGFILE_WIDTH / REGFILE_DEPTH : default register width and count
//   MAX_NWR / MAX_AW              : sizing limits for the padded write-port bus
//   wr_hit()                      : highest-index write port hitting an address
package regfile_pkg;

    localparam int REGFILE_WIDTH = 32;
    localparam int REGFILE_DEPTH = 32;

    // The write-port bus is zero-padded to these limits so that a single
    // non-parameterised function can serve every instance.
    localparam int MAX_NWR = 2;
    localparam int MAX_AW  = 16;
    localparam int IDX_W   = $clog2(MAX_NWR);

    typedef logic [MAX_NWR*MAX_AW-1:0] wr_addr_bus_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } wr_hit_t;

    // Later ports overwrite earlier ones, so the highest-index match wins.
    // Address 0 never hits: writes there are dropped.
    function automatic wr_hit_t wr_hit(input logic [MAX_NWR-1:0] en,
                                       input wr_addr_bus_t       addrs,
                                       input logic [MAX_AW-1:0]  addr);
        wr_hit_t r;
        r = '0;
        if (addr != '0) begin
            for (int w = 0; w < MAX_NWR; w++) begin
                if (en[w] && (addrs[w*MAX_AW +: MAX_AW] == addr)) begin
                    r.hit = 1'b1;
                    r.idx = IDX_W'(w);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending bit per register.
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active-low
//   iss_valid : issue strobe, marks iss_addr pending
//   iss_addr  : destination register being issued
//   clr_vec   : per-register writeback clear
//   busy_vec  : pending bits, bit 0 always 0
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = REGFILE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    input  logic [$clog2(DEPTH)-1:0] iss_addr,
    input  logic [DEPTH-1:0]         clr_vec,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DEPTH-1:0] set_vec;

    always_comb begin
        set_vec = '0;
        if (iss_valid && (iss_addr != '0)) begin
            set_vec[iss_addr] = 1'b1;
        end
    end

    // Set is OR-ed after the clear so a new producer issued in the same
    // cycle as the old writeback keeps the register busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= ((busy_vec & ~clr_vec) | set_vec) & ~DEPTH'(1);
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: NRD-read / NWR-write register file with register 0 tied to
// zero and an integrated busy scoreboard.
//   clk, rst (async, active-low)
//   rd_addr / rd_data / rd_busy : combinational read ports, packed per port
//   wr_en / wr_addr / wr_data   : writeback ports, highest index wins conflicts
//   iss_valid / iss_addr        : issue strobe setting the pending bit
//   busy_vec                    : full scoreboard
// Optional macro REGFILE_WRITE_BYPASS_EN: same-cycle writes are forwarded to
// matching read ports and clear their rd_busy unless re-issued that cycle.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = REGFILE_WIDTH,
    parameter int DEPTH = REGFILE_DEPTH,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NRD*$clog2(DEPTH)-1:0] rd_addr,
    output logic [NRD*WIDTH-1:0]         rd_data,
    output logic [NRD-1:0]               rd_busy,
    input  logic [NWR-1:0]               wr_en,
    input  logic [NWR*$clog2(DEPTH)-1:0] wr_addr,
    input  logic [NWR*WIDTH-1:0]         wr_data,
    input  logic                         iss_valid,
    input  logic [$clog2(DEPTH)-1:0]     iss_addr,
    output logic [DEPTH-1:0]             busy_vec
);

    localparam int AW = $clog2(DEPTH);

    logic [MAX_NWR-1:0] en_pad;
    wr_addr_bus_t       addr_pad;
    logic [WIDTH-1:0]   wd [MAX_NWR];
    wr_hit_t            hit [DEPTH];
    logic [DEPTH-1:0]   clr_vec;
    logic [WIDTH-1:0]   mem [DEPTH];

    // Widen the write ports to the fixed bus the package helper expects.
    always_comb begin
        en_pad   = '0;
        addr_pad = '0;
        for (int w = 0; w < MAX_NWR; w++) begin
            wd[w] = '0;
        end
        for (int w = 0; w < NWR; w++) begin
            en_pad[w]                        = wr_en[w];
            addr_pad[w*MAX_AW +: MAX_AW]     = MAX_AW'(wr_addr[w*AW +: AW]);
            wd[w]                            = wr_data[w*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            hit[r]     = wr_hit(en_pad, addr_pad, MAX_AW'(r));
            clr_vec[r] = hit[r].hit;
        end
    end

    // mem[0] is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (hit[r].hit) begin
                    mem[r] <= wd[hit[r].idx];
                end
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH(DEPTH)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_valid(iss_valid),
        .iss_addr (iss_addr),
        .clr_vec  (clr_vec),
        .busy_vec (busy_vec)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        logic             b;

        assign a = rd_addr[p*AW +: AW];

`ifdef REGFILE_WRITE_BYPASS_EN
        wr_hit_t bh;
        assign bh = wr_hit(en_pad, addr_pad, MAX_AW'(a));

        // Forwarding is suppressed while reset is held so reads stay zero.
        always_comb begin
            d = (a == '0) ? '0 : mem[a];
            b = busy_vec[a];
            if (rst && bh.hit) begin
                d = wd[bh.idx];
                b = iss_valid && (iss_addr == a);
            end
        end
`else
        always_comb begin
            d = (a == '0) ? '0 : mem[a];
            b = busy_vec[a];
        end
`endif

        assign rd_data[p*WIDTH +: WIDTH] = d;
        assign rd_busy[p]                = b;
    end

endmodule
